gate_freq_counter: RTL and testbench
====================================

Name: gate_freq_counter

Overview:
- Consumes the periodic one-cycle gate strobe from the 1 s timebase and measures the frequency of an asynchronous input by counting its rising edges between successive gate strobes.
- Publishes the count with a one-cycle valid pulse and flags saturation.
- Detects a missing gate through a watchdog.
- Sits beside the timebase in the AWG top level and feeds the status/readback path with measured output or reference frequency.

Parameters:
- CNT_W, 28, width of the edge counter and of freq.
- SYNC_STAGES, 2, flip-flop stages on sig_in before edge detection; minimum 2.
- GATE_TIMEOUT, 28'd134217727, clk cycles without a gate rising edge before gate_lost asserts; must be nonzero.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- gate  in  1  gate strobe from the timebase; internally rising-edge detected.
- sig_in  in  1  asynchronous signal under measurement.
- enable  in  1  measurement enable, synchronous to clk.
- freq  out  CNT_W  edge count of the last complete window.
- freq_valid  out  1  one-cycle pulse when freq updates.
- overflow  out  1  the window reported with freq saturated; updates with freq.
- gate_lost  out  1  level; watchdog expired since the last gate edge.

Behaviour:

Reset (rst_n low, asynchronous):
- freq=0, freq_valid=0, overflow=0, gate_lost=0.
- Sync chain, edge registers, counters and watchdog are cleared.
- State is IDLE.
- Reset asserted mid-window discards the window; no valid pulse is produced.

Input handling:
- sig_in passes through SYNC_STAGES flops, then one edge register.
- sig_edge = synced & ~prev.
- gate is registered once; gate_edge = gate & ~gate_q. A gate held high for N cycles counts once.

States:
- IDLE: enable=0. Counter and watchdog are held at 0. freq and overflow hold their last values. freq_valid=0. Goes to ARM when enable=1.
- ARM: waits for the first gate_edge, with the edge counter held at 0. On gate_edge, goes to MEASURE and starts counting the following cycle. No valid pulse is produced, because the first window is partial.
- MEASURE:
  - cnt increments on each sig_edge.
  - On gate_edge the register updates are: freq <= cnt + sig_edge (saturated), overflow <= sat flag, freq_valid <= 1.
  - cnt restarts at 0, and the coincident edge belongs to the closing window.
  - The state stays MEASURE.
- From any state, enable=0 goes to IDLE on the next edge. A window in progress is discarded with no valid pulse.

Latency and arithmetic:
- freq and freq_valid register one cycle after gate_edge is detected, i.e. 2 clk after gate rises.
- Counter arithmetic is unsigned CNT_W bits.
- An increment at all-ones stays at all-ones and sets the internal sat flag. sat clears when the window restarts.

Watchdog:
- Counts clk cycles in ARM and MEASURE; resets to 0 on gate_edge; held at 0 in IDLE.
- On reaching GATE_TIMEOUT:
  - gate_lost <= 1.
  - State goes to ARM, cnt is cleared, and no valid pulse is produced.
  - The watchdog stops at GATE_TIMEOUT (no wrap).
- gate_lost clears on the next gate_edge and stays 0 in IDLE.
- If gate_edge and expiry fall in the same cycle, the gate wins: normal window close, no gate_lost.

Other rules:
- freq_valid is never high for two consecutive cycles.
- sig_in toggling faster than clk/2 is out of spec; the count is then undefined but never exceeds saturation.

Test Plan:
All scenarios use CNT_W=8 and GATE_TIMEOUT=50 unless noted.
1. Reset behaviour: rst_n low, then high with enable=1, gate every 40 clk, sig_in period 4 clk. Expect the first window to produce no valid pulse. Each subsequent window gives freq=10, overflow=0, and freq_valid one cycle, 2 clk after gate rises.
2. Coincident edge and wide gate: a sig_in edge is synchronized to reach detection in the same cycle as gate_edge. Expect it counted in the closing window (count+1) and absent from the next. Also hold gate high for 3 clk; expect exactly one window close.
3. Saturation: sig_in period 2 clk (≈300 edges per window of 600 clk), GATE_TIMEOUT=1000. Expect freq=255 and overflow=1. The next window with 8 edges reports freq=8 and overflow=0.
4. Missing gate: stop gate after one window. Expect gate_lost=1 exactly 50 clk after the last gate_edge, and no freq_valid. Restarting the gate clears gate_lost at the first gate_edge; the next full window reports normally.
5. Disable and reset mid-window: drop enable mid-window, and separately pulse rst_n low mid-window. Expect no freq_valid for the aborted window. With enable, freq keeps its prior value; with rst_n, freq=0 immediately (asynchronous). On re-enable, the ARM partial window is skipped.

Source files
------------

// File: rtl/gate_freq_counter.sv
// gate_freq_counter: counts sig_in rising edges between gate strobes,
// reports a saturating count with a valid pulse, and watches for a lost gate.
module gate_freq_counter #(
  parameter int CNT_W        = 28,
  parameter int SYNC_STAGES  = 2,
  parameter int GATE_TIMEOUT = 28'd134217727
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gate,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic             gate_lost
);

  localparam int WD_W = $clog2(GATE_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(GATE_TIMEOUT);
  localparam logic [WD_W-1:0] WD_PRE = WD_W'(GATE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic sig_prev_q;
  logic gate_s_q, gate_q;
  logic sig_edge, gate_edge;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc, cnt_sat;
  logic carry;
  logic sat_q, sat_d;

  logic [WD_W-1:0] wd_q, wd_d;

  logic [CNT_W-1:0] freq_d;
  logic ovf_d, valid_d, lost_d;

  assign sig_edge  = sync_q[SYNC_STAGES-1] & ~sig_prev_q;
  assign gate_edge = gate_s_q & ~gate_q;

  assign {carry, cnt_inc} = {1'b0, cnt_q}
                          + (CNT_W+1)'(sig_edge);
  assign cnt_sat = carry ? '1 : cnt_inc;

  // Synchronise sig_in and register gate for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      sig_prev_q <= 1'b0;
      gate_s_q   <= 1'b0;
      gate_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_prev_q <= sync_q[SYNC_STAGES-1];
      gate_s_q   <= gate;
      gate_q     <= gate_s_q;
    end
  end

  // State, counters and published results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      wd_q       <= '0;
      freq       <= '0;
      overflow   <= 1'b0;
      freq_valid <= 1'b0;
      gate_lost  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      wd_q       <= wd_d;
      freq       <= freq_d;
      overflow   <= ovf_d;
      freq_valid <= valid_d;
      gate_lost  <= lost_d;
    end
  end

  // Next-state: window open/close, saturation and watchdog expiry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    wd_d    = wd_q;
    freq_d  = freq;
    ovf_d   = overflow;
    valid_d = 1'b0;
    lost_d  = gate_lost;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      sat_d   = 1'b0;
      wd_d    = '0;
      lost_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
          sat_d   = 1'b0;
          wd_d    = '0;
        end
        ARM: begin
          cnt_d = '0;
          sat_d = 1'b0;
          if (gate_edge) begin
            state_d = MEASURE;
            wd_d    = '0;
            lost_d  = 1'b0;
          end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WD_W'(1);
            if (wd_q == WD_PRE) lost_d = 1'b1;
          end
        end
        MEASURE: begin
          if (gate_edge) begin
            freq_d  = cnt_sat;
            ovf_d   = sat_q | carry;
            valid_d = 1'b1;
            cnt_d   = '0;
            sat_d   = 1'b0;
            wd_d    = '0;
            lost_d  = 1'b0;
          end else if (wd_q == WD_PRE) begin
            state_d = ARM;
            wd_d    = WD_MAX;
            lost_d  = 1'b1;
            cnt_d   = '0;
            sat_d   = 1'b0;
          end else begin
            wd_d  = wd_q + WD_W'(1);
            cnt_d = cnt_sat;
            sat_d = sat_q | carry;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_freq_counter.sv
// tb_gate_freq_counter: random and directed stimulus on two instances
// (short and long watchdog) against a window-level reference model.
module tb_gate_freq_counter;

  localparam int MAXC = 255;

  logic clk = 1'b0;
  logic rst_n, gate, sig_in, enable;
  logic [7:0] freq0, freq1;
  logic valid0, valid1, ovf0, ovf1, lost0, lost1;

  always #5 clk = ~clk;

  gate_freq_counter #(
    .CNT_W(8), .SYNC_STAGES(2), .GATE_TIMEOUT(50)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .gate(gate),
    .sig_in(sig_in), .enable(enable),
    .freq(freq0), .freq_valid(valid0),
    .overflow(ovf0), .gate_lost(lost0)
  );

  gate_freq_counter #(
    .CNT_W(8), .SYNC_STAGES(2), .GATE_TIMEOUT(1000)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .gate(gate),
    .sig_in(sig_in), .enable(enable),
    .freq(freq1), .freq_valid(valid1),
    .overflow(ovf1), .gate_lost(lost1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // stimulus controls
  int g_per = 0, g_wid = 1, gph = 0;
  int s_per = 4, sph = 0, smode = 0;
  logic en_req = 1'b0;
  int cyc = 0, g_rise = -100;
  int last_val = 0, lost_rise = 0;
  logic lost0_p = 1'b0;
  int rst_cnt = 0;

  // reference model: input history and per-instance window state
  localparam int M_IDLE = 0, M_ARM = 1, M_MEAS = 2;
  logic [7:0] sh, gh;
  int tmo [2] = '{50, 1000};
  int mode [2], n [2], since [2];
  int e_freq [2], e_ovf [2], e_val [2], e_lost [2];

  task automatic model_clear();
    sh = '0;
    gh = '0;
    for (int i = 0; i < 2; i++) begin
      mode[i] = M_IDLE; n[i] = 0; since[i] = 0;
      e_freq[i] = 0; e_ovf[i] = 0;
      e_val[i] = 0; e_lost[i] = 0;
    end
  endtask

  task automatic model_step();
    int se, ge, tot;
    if (!rst_n) begin
      model_clear();
      return;
    end
    sh = {sh[6:0], sig_in};
    gh = {gh[6:0], gate};
    se = int'(sh[2] & ~sh[3]);
    ge = int'(gh[1] & ~gh[2]);
    for (int i = 0; i < 2; i++) begin
      e_val[i] = 0;
      if (!enable) begin
        mode[i] = M_IDLE; n[i] = 0;
        since[i] = 0; e_lost[i] = 0;
      end else if (mode[i] == M_IDLE) begin
        mode[i] = M_ARM;
      end else if (ge != 0) begin
        if (mode[i] == M_MEAS) begin
          tot = n[i] + se;
          e_freq[i] = (tot > MAXC) ? MAXC : tot;
          e_ovf[i]  = (tot > MAXC) ? 1 : 0;
          e_val[i]  = 1;
        end
        mode[i] = M_MEAS; n[i] = 0;
        since[i] = 0; e_lost[i] = 0;
      end else if (since[i] < tmo[i]) begin
        since[i]++;
        if (since[i] == tmo[i]) begin
          e_lost[i] = 1; mode[i] = M_ARM; n[i] = 0;
        end else if (mode[i] == M_MEAS) begin
          n[i] += se;
        end
      end
    end
  endtask

  task automatic gen();
    logic g_prev, sig_c;
    g_prev = gate;
    enable = en_req;
    if (g_per != 0) begin
      gate  = (gph < g_wid);
      sig_c = (gph == g_per - 1) || (gph == 0);
      gph   = (gph + 1) % g_per;
    end else begin
      gate  = 1'b0;
      sig_c = 1'b0;
      gph   = 0;
    end
    if (gate && !g_prev) g_rise = cyc;
    case (smode)
      0: begin
        sig_in = (sph < s_per / 2);
        sph = (sph + 1) % s_per;
      end
      1: sig_in = sig_c;
      default: sig_in = 1'($urandom);
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    chk("d0_freq", freq0, e_freq[0]);
    chk("d0_valid", valid0, e_val[0]);
    chk("d0_ovf", ovf0, e_ovf[0]);
    chk("d0_lost", lost0, e_lost[0]);
    chk("d1_freq", freq1, e_freq[1]);
    chk("d1_valid", valid1, e_val[1]);
    chk("d1_ovf", ovf1, e_ovf[1]);
    chk("d1_lost", lost1, e_lost[1]);
    if (valid0) begin
      last_val = cyc;
      chk("val_lat", cyc - g_rise, 2);
    end
    if (lost0 && !lost0_p) lost_rise = cyc;
    lost0_p = lost0;
    gen();
    if (rst_cnt > 0) begin
      rst_cnt--;
      if (rst_cnt == 0) rst_n = 1'b1;
    end
    model_step();
  endtask

  task automatic assert_reset(input int cycles);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_freq", freq0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_lost", lost0, 0);
    chk("rst_freq1", freq1, 0);
    rst_cnt = cycles;
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!valid0 && k < 200) begin
      cycle();
      k++;
    end
    chk("wait_valid", valid0, 1);
  endtask

  task automatic set_sig(input int mode_i, input int per);
    smode = mode_i;
    s_per = per;
    sph = 0;
  endtask

  task automatic set_gate(input int per, input int wid);
    g_per = per;
    g_wid = wid;
    gph = 0;
  endtask

  initial begin
    rst_n = 1'b1;
    gate = 1'b0;
    sig_in = 1'b0;
    enable = 1'b0;
    model_clear();
    #1 rst_n = 1'b0;
    #1;
    chk("init_freq", freq0, 0);
    chk("init_valid", valid0, 0);
    chk("init_ovf", ovf0, 0);
    chk("init_lost", lost0, 0);
    rst_cnt = 2;

    // basic windows: 10 edges per 40-cycle gate
    en_req = 1'b1;
    set_gate(40, 1);
    set_sig(0, 4);
    repeat (200) cycle();
    chk("s1_freq", freq0, 10);
    chk("s1_ovf", ovf0, 0);

    // edge coincident with gate edge, 3-cycle-wide gate
    set_gate(40, 3);
    set_sig(1, 0);
    repeat (200) cycle();
    chk("coinc_freq", freq0, 1);

    // saturation then recovery on the long-watchdog instance
    set_gate(600, 1);
    set_sig(0, 2);
    repeat (1900) cycle();
    chk("sat_freq", freq1, 255);
    chk("sat_ovf", ovf1, 1);
    set_sig(0, 75);
    repeat (1900) cycle();
    chk("slow_freq", freq1, 8);
    chk("slow_ovf", ovf1, 0);

    // missing gate
    set_gate(40, 1);
    set_sig(0, 4);
    repeat (120) cycle();
    wait_valid();
    set_gate(0, 1);
    repeat (80) cycle();
    chk("lost_lvl", lost0, 1);
    chk("lost_lat", lost_rise - last_val, 50);
    chk("d1_nolost", lost1, 0);
    set_gate(40, 1);
    repeat (100) cycle();
    chk("lost_clr", lost0, 0);
    chk("restart_freq", freq0, 10);

    // disable mid-window
    wait_valid();
    repeat (15) cycle();
    en_req = 1'b0;
    repeat (5) cycle();
    chk("dis_hold", freq0, 10);
    en_req = 1'b1;
    repeat (150) cycle();

    // reset mid-window
    wait_valid();
    repeat (15) cycle();
    assert_reset(3);
    repeat (150) cycle();
    chk("post_rst_freq", freq0, 10);

    // randomized gates, signals and enable toggles
    for (int blk = 0; blk < 30; blk++) begin
      set_gate(int'($urandom_range(20, 45)),
               int'($urandom_range(1, 3)));
      set_sig(int'($urandom_range(0, 2)),
              2 * int'($urandom_range(1, 4)));
      repeat (100) begin
        if ($urandom_range(0, 199) == 0) en_req = ~en_req;
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
